// File: rtl/cmac_actv_pkg.sv
// Shared constants and helpers for the CMAC active-staging block.
// Optional perf counters in the top are enabled by defining CMAC_ACTV_PERF_EN.
package cmac_actv_pkg;

    localparam int DEF_BPE       = 8;
    localparam int DEF_ATOMC     = 8;
    localparam int DEF_NUM_CELLS = 4;
    localparam int DEF_SD_DEPTH  = 2;

    // Widest element the zeroing helper handles; BPE must not exceed this.
    localparam int MAX_BPE = 64;

    // Returns the element unchanged when its mask bit is set, otherwise zero.
    function automatic logic [MAX_BPE-1:0] elem_zero(input logic [MAX_BPE-1:0] data,
                                                     input logic               mask);
        return mask ? data : '0;
    endfunction

endpackage

// File: rtl/cmac_actv_wt_shadow.sv
// Per-cell weight shadow queue: SD_DEPTH-entry FIFO holding pre-masked
// kernels for future stripes. Storage is not reset; pointers and count are.
// Caller guarantees no push when full and no pop when empty.
module cmac_actv_wt_shadow
    import cmac_actv_pkg::*;
#(
    parameter int BPE      = DEF_BPE,
    parameter int ATOMC    = DEF_ATOMC,
    parameter int SD_DEPTH = DEF_SD_DEPTH,
    localparam int DW      = BPE * ATOMC,
    localparam int CW      = $clog2(SD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [DW-1:0]    push_data_i,
    input  logic [ATOMC-1:0] push_nz_i,
    input  logic             pop_i,
    output logic [CW-1:0]    cnt_o,
    output logic [DW-1:0]    head_data_o,
    output logic [ATOMC-1:0] head_nz_o
);

    localparam int PW = (SD_DEPTH > 1) ? $clog2(SD_DEPTH) : 1;

    logic [DW-1:0]    mem_data_q [SD_DEPTH];
    logic [ATOMC-1:0] mem_nz_q   [SD_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer advance and occupancy; simultaneous push and pop leave cnt unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_data_q[wr_ptr_q] <= push_data_i;
            mem_nz_q[wr_ptr_q]   <= push_nz_i;
        end
    end

    assign cnt_o       = cnt_q;
    assign head_data_o = mem_data_q[rd_ptr_q];
    assign head_nz_o   = mem_nz_q[rd_ptr_q];

endmodule

// File: rtl/cmac_core_actv_stage.sv
// CMAC active-staging stage: two-cycle data pipeline with masked-element
// zeroing, per-cell weight shadow queues popped at stripe start, and
// per-cell weight underflow flags.
// Optional perf counters (stripes, weight stall cycles) under CMAC_ACTV_PERF_EN.
module cmac_core_actv_stage
    import cmac_actv_pkg::*;
#(
    parameter int BPE       = DEF_BPE,
    parameter int ATOMC     = DEF_ATOMC,
    parameter int NUM_CELLS = DEF_NUM_CELLS,
    parameter int SD_DEPTH  = DEF_SD_DEPTH,
    localparam int DW       = BPE * ATOMC,
    localparam int CW       = $clog2(SD_DEPTH + 1)
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rst,
    input  logic                      in_dat_pvld,
    input  logic [DW-1:0]             in_dat_data,
    input  logic [ATOMC-1:0]          in_dat_mask,
    input  logic                      in_dat_stripe_st,
    input  logic                      in_dat_stripe_end,
    input  logic                      in_wt_pvld,
    output logic                      in_wt_prdy,
    input  logic [NUM_CELLS-1:0]      in_wt_sel,
    input  logic [DW-1:0]             in_wt_data,
    input  logic [ATOMC-1:0]          in_wt_mask,
    output logic                      dat_actv_pvld,
    output logic [DW-1:0]             dat_actv_data,
    output logic [ATOMC-1:0]          dat_actv_nz,
    output logic                      dat_actv_stripe_st,
    output logic                      dat_actv_stripe_end,
    output logic [NUM_CELLS-1:0]      wt_actv_pvld,
    output logic [NUM_CELLS*DW-1:0]   wt_actv_data,
    output logic [NUM_CELLS*ATOMC-1:0] wt_actv_nz,
    output logic [NUM_CELLS*CW-1:0]   wt_sd_cnt,
    output logic [NUM_CELLS-1:0]      wt_underflow
`ifdef CMAC_ACTV_PERF_EN
   ,output logic [31:0]               perf_stripe_cnt,
    output logic [31:0]               perf_wt_stall_cnt
`endif
);

    function automatic logic [DW-1:0] mask_atom(input logic [DW-1:0]    data,
                                                input logic [ATOMC-1:0] mask);
        logic [DW-1:0] res;
        res = '0;
        for (int k = 0; k < ATOMC; k++) begin
            res[k*BPE +: BPE] = BPE'(elem_zero(MAX_BPE'(data[k*BPE +: BPE]), mask[k]));
        end
        return res;
    endfunction

    logic                 pre_pvld_q, pre_st_q, pre_end_q;
    logic [DW-1:0]        pre_data_q;
    logic [ATOMC-1:0]     pre_nz_q;
    logic                 dat_pvld_q, dat_st_q, dat_end_q;
    logic [DW-1:0]        dat_data_q;
    logic [ATOMC-1:0]     dat_nz_q;

    logic                 rdy_en_q;
    logic                 wt_acc;
    logic [DW-1:0]        wt_push_data;
    logic [NUM_CELLS-1:0] push_c, pop_c;

    logic [NUM_CELLS-1:0][CW-1:0]    sd_cnt;
    logic [NUM_CELLS-1:0][DW-1:0]    head_data;
    logic [NUM_CELLS-1:0][ATOMC-1:0] head_nz;

    logic [NUM_CELLS-1:0]            wt_pvld_q, wt_pvld_d;
    logic [NUM_CELLS-1:0][DW-1:0]    wt_data_q, wt_data_d;
    logic [NUM_CELLS-1:0][ATOMC-1:0] wt_nz_q, wt_nz_d;
    logic [NUM_CELLS-1:0]            uflow_q, uflow_d;

    // Two-stage data pipeline; data/nz only captured on valid beats.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            pre_pvld_q <= 1'b0;
            pre_st_q   <= 1'b0;
            pre_end_q  <= 1'b0;
            pre_data_q <= '0;
            pre_nz_q   <= '0;
            dat_pvld_q <= 1'b0;
            dat_st_q   <= 1'b0;
            dat_end_q  <= 1'b0;
            dat_data_q <= '0;
            dat_nz_q   <= '0;
        end else begin
            pre_pvld_q <= in_dat_pvld;
            pre_st_q   <= in_dat_stripe_st & in_dat_pvld;
            pre_end_q  <= in_dat_stripe_end & in_dat_pvld;
            if (in_dat_pvld) begin
                pre_data_q <= mask_atom(in_dat_data, in_dat_mask);
                pre_nz_q   <= in_dat_mask;
            end
            dat_pvld_q <= pre_pvld_q;
            dat_st_q   <= pre_st_q;
            dat_end_q  <= pre_end_q;
            dat_data_q <= pre_data_q;
            dat_nz_q   <= pre_nz_q;
        end
    end

    // Holds prdy low through reset and for the first cycle after it.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) rdy_en_q <= 1'b0;
        else                rdy_en_q <= 1'b1;
    end

    // Ready only if every selected cell has room (no same-cycle pop credit).
    always_comb begin
        in_wt_prdy = rdy_en_q;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (in_wt_sel[c] && (sd_cnt[c] >= CW'(SD_DEPTH))) in_wt_prdy = 1'b0;
        end
    end

    assign wt_acc       = in_wt_pvld & in_wt_prdy;
    assign wt_push_data = mask_atom(in_wt_data, in_wt_mask);

    // Per-cell push/pop strobes; pops only from non-empty queues at stripe start.
    always_comb begin
        push_c = '0;
        pop_c  = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            push_c[c] = wt_acc & in_wt_sel[c];
            pop_c[c]  = pre_st_q & (sd_cnt[c] != '0);
        end
    end

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        cmac_actv_wt_shadow #(
            .BPE      (BPE),
            .ATOMC    (ATOMC),
            .SD_DEPTH (SD_DEPTH)
        ) u_shadow (
            .clk         (nvdla_core_clk),
            .rst         (nvdla_core_rst),
            .push_i      (push_c[g]),
            .push_data_i (wt_push_data),
            .push_nz_i   (in_wt_mask),
            .pop_i       (pop_c[g]),
            .cnt_o       (sd_cnt[g]),
            .head_data_o (head_data[g]),
            .head_nz_o   (head_nz[g])
        );
    end

    // Active weights: stripe start reloads (wins over a coincident end), end drops valid.
    always_comb begin
        wt_pvld_d = wt_pvld_q;
        wt_data_d = wt_data_q;
        wt_nz_d   = wt_nz_q;
        uflow_d   = '0;
        if (pre_st_q) begin
            for (int c = 0; c < NUM_CELLS; c++) begin
                if (sd_cnt[c] != '0) begin
                    wt_pvld_d[c] = 1'b1;
                    wt_data_d[c] = head_data[c];
                    wt_nz_d[c]   = head_nz[c];
                end else begin
                    wt_pvld_d[c] = 1'b0;
                    wt_data_d[c] = '0;
                    wt_nz_d[c]   = '0;
                    uflow_d[c]   = 1'b1;
                end
            end
        end else if (dat_end_q) begin
            wt_pvld_d = '0;
        end
    end

    // Active weight registers.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wt_pvld_q <= '0;
            wt_data_q <= '0;
            wt_nz_q   <= '0;
            uflow_q   <= '0;
        end else begin
            wt_pvld_q <= wt_pvld_d;
            wt_data_q <= wt_data_d;
            wt_nz_q   <= wt_nz_d;
            uflow_q   <= uflow_d;
        end
    end

`ifdef CMAC_ACTV_PERF_EN
    logic [31:0] perf_stripe_q, perf_stall_q;

    // Saturating stripe and weight-stall counters.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            perf_stripe_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (pre_st_q && (perf_stripe_q != '1))
                perf_stripe_q <= perf_stripe_q + 32'd1;
            if (in_wt_pvld && !in_wt_prdy && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_stripe_cnt   = perf_stripe_q;
    assign perf_wt_stall_cnt = perf_stall_q;
`endif

    assign dat_actv_pvld       = dat_pvld_q;
    assign dat_actv_data       = dat_data_q;
    assign dat_actv_nz         = dat_nz_q;
    assign dat_actv_stripe_st  = dat_st_q;
    assign dat_actv_stripe_end = dat_end_q;
    assign wt_actv_pvld        = wt_pvld_q;
    assign wt_actv_data        = wt_data_q;
    assign wt_actv_nz          = wt_nz_q;
    assign wt_sd_cnt           = sd_cnt;
    assign wt_underflow        = uflow_q;

endmodule

// File: tb/tb_cmac_core_actv_stage.sv
// Directed bench for cmac_core_actv_stage with default parameters
// (BPE=8, ATOMC=8, NUM_CELLS=4, SD_DEPTH=2).
module tb_cmac_core_actv_stage;

    localparam int DW = 64;
    localparam int NC = 4;
    localparam int CW = 2;

    logic              nvdla_core_clk = 1'b0;
    logic              nvdla_core_rst;
    logic              in_dat_pvld;
    logic [DW-1:0]     in_dat_data;
    logic [7:0]        in_dat_mask;
    logic              in_dat_stripe_st;
    logic              in_dat_stripe_end;
    logic              in_wt_pvld;
    logic              in_wt_prdy;
    logic [NC-1:0]     in_wt_sel;
    logic [DW-1:0]     in_wt_data;
    logic [7:0]        in_wt_mask;
    logic              dat_actv_pvld;
    logic [DW-1:0]     dat_actv_data;
    logic [7:0]        dat_actv_nz;
    logic              dat_actv_stripe_st;
    logic              dat_actv_stripe_end;
    logic [NC-1:0]     wt_actv_pvld;
    logic [NC*DW-1:0]  wt_actv_data;
    logic [NC*8-1:0]   wt_actv_nz;
    logic [NC*CW-1:0]  wt_sd_cnt;
    logic [NC-1:0]     wt_underflow;
`ifdef CMAC_ACTV_PERF_EN
    logic [31:0]       perf_stripe_cnt;
    logic [31:0]       perf_wt_stall_cnt;
`endif

    cmac_core_actv_stage dut (
        .nvdla_core_clk      (nvdla_core_clk),
        .nvdla_core_rst      (nvdla_core_rst),
        .in_dat_pvld         (in_dat_pvld),
        .in_dat_data         (in_dat_data),
        .in_dat_mask         (in_dat_mask),
        .in_dat_stripe_st    (in_dat_stripe_st),
        .in_dat_stripe_end   (in_dat_stripe_end),
        .in_wt_pvld          (in_wt_pvld),
        .in_wt_prdy          (in_wt_prdy),
        .in_wt_sel           (in_wt_sel),
        .in_wt_data          (in_wt_data),
        .in_wt_mask          (in_wt_mask),
        .dat_actv_pvld       (dat_actv_pvld),
        .dat_actv_data       (dat_actv_data),
        .dat_actv_nz         (dat_actv_nz),
        .dat_actv_stripe_st  (dat_actv_stripe_st),
        .dat_actv_stripe_end (dat_actv_stripe_end),
        .wt_actv_pvld        (wt_actv_pvld),
        .wt_actv_data        (wt_actv_data),
        .wt_actv_nz          (wt_actv_nz),
        .wt_sd_cnt           (wt_sd_cnt),
        .wt_underflow        (wt_underflow)
`ifdef CMAC_ACTV_PERF_EN
       ,.perf_stripe_cnt     (perf_stripe_cnt),
        .perf_wt_stall_cnt   (perf_wt_stall_cnt)
`endif
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    mask;
        logic [DW-1:0] exp_data;
        logic [7:0]    exp_nz;
    } dvec_t;

    dvec_t vecs[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic dat_idle();
        in_dat_pvld       = 1'b0;
        in_dat_data       = '0;
        in_dat_mask       = '0;
        in_dat_stripe_st  = 1'b0;
        in_dat_stripe_end = 1'b0;
    endtask

    task automatic wt_idle();
        in_wt_pvld = 1'b0;
        in_wt_sel  = '0;
        in_wt_data = '0;
        in_wt_mask = '0;
    endtask

    task automatic dat_beat(input logic st, input logic en, input logic [DW-1:0] d, input logic [7:0] m);
        in_dat_pvld       = 1'b1;
        in_dat_data       = d;
        in_dat_mask       = m;
        in_dat_stripe_st  = st;
        in_dat_stripe_end = en;
    endtask

    task automatic wt_push(input logic [NC-1:0] sel, input logic [DW-1:0] d, input logic [7:0] m);
        in_wt_pvld = 1'b1;
        in_wt_sel  = sel;
        in_wt_data = d;
        in_wt_mask = m;
    endtask

    initial begin
        vecs[0] = '{64'h1122334455667788, 8'hFF, 64'h1122334455667788, 8'hFF};
        vecs[1] = '{64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h00000000AAAAAAAA, 8'h0F};
        vecs[2] = '{64'h0102030405060708, 8'hA5, 64'h0100030000060008, 8'hA5};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0000000000000000, 8'h00};
        vecs[4] = '{64'hDEADBEEFCAFEF00D, 8'h81, 64'hDE0000000000000D, 8'h81};

        dat_idle();
        wt_idle();
        nvdla_core_rst = 1'b1;
        step();
        step();
        check("rst_dat_pvld", dat_actv_pvld, 0);
        check("rst_dat_data", dat_actv_data, 0);
        check("rst_wt_pvld", wt_actv_pvld, 0);
        check("rst_sd_cnt", wt_sd_cnt, 0);
        check("rst_uflow", wt_underflow, 0);
        check("rst_prdy_low", in_wt_prdy, 0);
        nvdla_core_rst = 1'b0;
        step();
        check("prdy_after_rst", in_wt_prdy, 1);

        // Data path table: two-cycle latency and element masking.
        for (int i = 0; i < 5; i++) begin
            dat_beat(1'b0, 1'b0, vecs[i].data, vecs[i].mask);
            step();
            dat_idle();
            step();
            check($sformatf("tbl%0d_pvld", i), dat_actv_pvld, 1);
            check($sformatf("tbl%0d_data", i), dat_actv_data, vecs[i].exp_data);
            check($sformatf("tbl%0d_nz", i), dat_actv_nz, vecs[i].exp_nz);
            step();
            check($sformatf("tbl%0d_pvld_drop", i), dat_actv_pvld, 0);
        end

        // Basic: one kernel in cell0, single-beat stripe (st and end).
        wt_push(4'b0001, 64'h0807060504030201, 8'hFF);
        #1;
        check("basic_prdy", in_wt_prdy, 1);
        step();
        wt_idle();
        check("basic_cnt", wt_sd_cnt, 8'h01);
        dat_beat(1'b1, 1'b1, 64'h1122334455667788, 8'hFF);
        step();
        dat_idle();
        check("basic_wt_pvld_t1", wt_actv_pvld, 4'b0000);
        step();
        check("basic_dat_pvld", dat_actv_pvld, 1);
        check("basic_dat_st", dat_actv_stripe_st, 1);
        check("basic_dat_end", dat_actv_stripe_end, 1);
        check("basic_wt_pvld", wt_actv_pvld, 4'b0001);
        check("basic_wt_data", wt_actv_data[63:0], 64'h0807060504030201);
        check("basic_wt_nz", wt_actv_nz[7:0], 8'hFF);
        check("basic_cnt_pop", wt_sd_cnt, 8'h00);
        check("basic_uflow", wt_underflow, 4'b1110);
        step();
        check("basic_wt_clear", wt_actv_pvld, 4'b0000);
        check("basic_uflow_pulse", wt_underflow, 4'b0000);

        // Weight masking, hold between start and end.
        wt_push(4'b0001, 64'h0807060504030201, 8'hF0);
        step();
        wt_idle();
        dat_beat(1'b1, 1'b0, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        step();
        dat_idle();
        step();
        check("wmask_data", wt_actv_data[63:0], 64'h0807060500000000);
        check("wmask_nz", wt_actv_nz[7:0], 8'hF0);
        check("wmask_dat", dat_actv_data, 64'h00000000AAAAAAAA);
        step();
        step();
        check("hold_pvld", wt_actv_pvld, 4'b0001);
        check("hold_data", wt_actv_data[63:0], 64'h0807060500000000);
        dat_beat(1'b0, 1'b1, 64'h0, 8'hFF);
        step();
        dat_idle();
        step();
        check("end_dat_flag", dat_actv_stripe_end, 1);
        check("end_pvld_still", wt_actv_pvld, 4'b0001);
        step();
        check("end_pvld_clear", wt_actv_pvld, 4'b0000);

        // Backpressure on a full cell1.
        wt_push(4'b0010, 64'h1111111111111111, 8'hFF);
        step();
        wt_push(4'b0010, 64'h2222222222222222, 8'hFF);
        step();
        check("bp_cnt_full", wt_sd_cnt, 8'h08);
        wt_push(4'b0010, 64'h3333333333333333, 8'hFF);
        #1;
        check("bp_prdy_full", in_wt_prdy, 0);
        wt_push(4'b0100, 64'h7777777777777777, 8'hFF);
        #1;
        check("bp_prdy_other", in_wt_prdy, 1);
        step();
        check("bp_cnt_other", wt_sd_cnt, 8'h18);
        wt_push(4'b0010, 64'h3333333333333333, 8'hFF);
        dat_beat(1'b1, 1'b0, 64'h0, 8'hFF);
        step();
        dat_idle();
        check("bp_prdy_no_bypass", in_wt_prdy, 0);
        check("bp_cnt_stalled", wt_sd_cnt, 8'h18);
        step();
        check("bp_pop_pvld", wt_actv_pvld, 4'b0110);
        check("bp_pop_uflow", wt_underflow, 4'b1001);
        check("bp_pop_cnt", wt_sd_cnt, 8'h04);
        check("bp_pop_prdy", in_wt_prdy, 1);
        check("bp_cell1_data", wt_actv_data[127:64], 64'h1111111111111111);
        check("bp_cell2_data", wt_actv_data[191:128], 64'h7777777777777777);
        step();
        wt_idle();
        check("bp_third_accepted", wt_sd_cnt, 8'h08);

        // Underflow: cell2 empty, cells 0,1,3 loaded (multi-hot push).
        wt_push(4'b1001, 64'h4444444444444444, 8'hFF);
        #1;
        check("uf_prdy", in_wt_prdy, 1);
        step();
        wt_idle();
        check("uf_cnt", wt_sd_cnt, 8'h49);
        dat_beat(1'b1, 1'b0, 64'h0, 8'hFF);
        step();
        dat_idle();
        step();
        check("uf_pvld", wt_actv_pvld, 4'b1011);
        check("uf_flag", wt_underflow, 4'b0100);
        check("uf_cell1", wt_actv_data[127:64], 64'h2222222222222222);
        check("uf_cell2_zero", wt_actv_data[191:128], 64'h0);
        check("uf_cell3", wt_actv_data[255:192], 64'h4444444444444444);
        check("uf_cnt_after", wt_sd_cnt, 8'h04);
        step();
        check("uf_pulse_end", wt_underflow, 4'b0000);
        check("uf_pvld_hold", wt_actv_pvld, 4'b1011);
        dat_beat(1'b0, 1'b1, 64'h0, 8'hFF);
        step();
        dat_idle();
        step();
        step();
        check("uf_end_clear", wt_actv_pvld, 4'b0000);

        // Back-to-back stripes on cell1 with two queued kernels.
        wt_push(4'b0010, 64'h6666666666666666, 8'hFF);
        step();
        wt_idle();
        dat_beat(1'b1, 1'b0, 64'h0, 8'hFF);
        step();
        dat_beat(1'b0, 1'b1, 64'h0, 8'hFF);
        check("b2b_cnt2", wt_sd_cnt, 8'h08);
        step();
        check("b2b_k1_pvld", wt_actv_pvld, 4'b0010);
        check("b2b_k1_data", wt_actv_data[127:64], 64'h3333333333333333);
        check("b2b_cnt1", wt_sd_cnt, 8'h04);
        check("b2b_k1_uflow", wt_underflow, 4'b1101);
        dat_beat(1'b1, 1'b1, 64'h0, 8'hFF);
        step();
        dat_idle();
        check("b2b_end_pvld", wt_actv_pvld, 4'b0010);
        check("b2b_end_flag", dat_actv_stripe_end, 1);
        step();
        check("b2b_k2_pvld", wt_actv_pvld, 4'b0010);
        check("b2b_k2_data", wt_actv_data[127:64], 64'h6666666666666666);
        check("b2b_cnt0", wt_sd_cnt, 8'h00);
        check("b2b_k2_st", dat_actv_stripe_st, 1);
        step();
        check("b2b_final_clear", wt_actv_pvld, 4'b0000);

        // Same-cycle push and pop on cell0, then reset mid-stripe.
        wt_push(4'b0001, 64'h8888888888888888, 8'hFF);
        step();
        wt_idle();
        dat_beat(1'b1, 1'b0, 64'h0, 8'hFF);
        step();
        dat_idle();
        wt_push(4'b0001, 64'h9999999999999999, 8'hFF);
        #1;
        check("pp_prdy", in_wt_prdy, 1);
        step();
        check("pp_cnt_same", wt_sd_cnt, 8'h01);
        check("pp_data", wt_actv_data[63:0], 64'h8888888888888888);
        wt_push(4'b0001, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        step();
        wt_idle();
        check("rst_pre_cnt", wt_sd_cnt, 8'h02);
        check("rst_pre_pvld", wt_actv_pvld, 4'b0001);
        nvdla_core_rst = 1'b1;
        dat_beat(1'b1, 1'b0, 64'h1234567812345678, 8'hFF);
        step();
        dat_idle();
        check("mrst_cnt", wt_sd_cnt, 8'h00);
        check("mrst_wt_pvld", wt_actv_pvld, 4'b0000);
        check("mrst_wt_data", wt_actv_data, 256'h0);
        check("mrst_dat_pvld", dat_actv_pvld, 0);
        check("mrst_dat_data", dat_actv_data, 64'h0);
        check("mrst_prdy", in_wt_prdy, 0);
        nvdla_core_rst = 1'b0;
        step();
        check("mrst_prdy_after", in_wt_prdy, 1);
        check("mrst_dat_pvld_after", dat_actv_pvld, 0);
        dat_beat(1'b1, 1'b0, 64'h0, 8'hFF);
        step();
        dat_idle();
        step();
        check("mrst_discarded_uflow", wt_underflow, 4'b1111);
        check("mrst_discarded_pvld", wt_actv_pvld, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
